// File: rtl/csr_timer_pkg.sv
// Shared constants for the LoongArch timer CSRs (TID/TCFG/TVAL/TICLR):
// CSR addresses, field positions and the ESTAT interrupt bit the timer drives.
package csr_timer_pkg;

  localparam logic [13:0] CSR_TID   = 14'h0040;
  localparam logic [13:0] CSR_TCFG  = 14'h0041;
  localparam logic [13:0] CSR_TVAL  = 14'h0042;
  localparam logic [13:0] CSR_TICLR = 14'h0044;

  localparam int TCFG_EN          = 0;
  localparam int TCFG_PERIODIC    = 1;
  localparam int TCFG_INITVAL_LSB = 2;
  localparam int TCFG_INITVAL_MSB = 31;
  localparam int TICLR_CLR        = 0;
  localparam int ESTAT_IS_11      = 11;

  function automatic logic is_timer_csr(input logic [13:0] num);
    logic hit;
    case (num)
      CSR_TID, CSR_TCFG, CSR_TVAL, CSR_TICLR: hit = 1'b1;
      default:                                hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/csr_timer_stable_counter.sv
// 64-bit free-running stable counter read by RDCNTVL.W / RDCNTVH.W.
module csr_timer_stable_counter
  import csr_timer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] cnt
);

  logic [63:0] cnt_q;
  logic [63:0] cnt_d;

  // next count, wrapping naturally at 2^64
  always_comb begin
    cnt_d = cnt_q + 64'd1;
  end

  // counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 64'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/csr_timer.sv
// LoongArch timer CSR block: TID/TCFG/TVAL/TICLR, countdown timer with
// one-shot/periodic modes, timer interrupt, and the 64-bit stable counter.
module csr_timer
  import csr_timer_pkg::*;
#(
  parameter int          TIMER_N = 32,
  parameter logic [31:0] CPU_ID  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] csr_num,
  input  logic        csr_re,
  input  logic        csr_we,
  input  logic [31:0] csr_wdata,
  output logic        csr_hit,
  output logic [31:0] csr_rdata,
  output logic        timer_int,
  output logic [63:0] stable_cnt,
  output logic [31:0] counter_id
);

  localparam logic [TIMER_N-1:0] TVAL_ZERO = {TIMER_N{1'b0}};
  localparam logic [TIMER_N-1:0] TVAL_ONE  = {{(TIMER_N-1){1'b0}}, 1'b1};
  localparam logic [TIMER_N-1:0] TVAL_ONES = {TIMER_N{1'b1}};

  logic [31:0]          tid_q, tid_d;
  logic                 en_q, en_d;
  logic                 per_q, per_d;
  logic                 armed_q, armed_d;
  logic                 int_q, int_d;
  logic [TIMER_N-3:0]   initval_q, initval_d;
  logic [TIMER_N-1:0]   tval_q, tval_d;
  logic                 wr_tid, wr_tcfg, wr_ticlr;
  logic                 expire;
  logic [31:0]          rdata_mux;

  assign wr_tid   = csr_we && (csr_num == CSR_TID);
  assign wr_tcfg  = csr_we && (csr_num == CSR_TCFG);
  assign wr_ticlr = csr_we && (csr_num == CSR_TICLR);

  // CSR writes, countdown and interrupt next-state
  always_comb begin
    tid_d     = tid_q;
    en_d      = en_q;
    per_d     = per_q;
    initval_d = initval_q;
    tval_d    = tval_q;
    armed_d   = armed_q;
    int_d     = int_q;
    expire    = 1'b0;

    if (wr_tid) begin
      tid_d = csr_wdata;
    end else begin
      tid_d = tid_q;
    end

    // a TCFG write pre-empts countdown and expiry for that cycle
    if (wr_tcfg) begin
      en_d      = csr_wdata[TCFG_EN];
      per_d     = csr_wdata[TCFG_PERIODIC];
      initval_d = csr_wdata[TIMER_N-1:TCFG_INITVAL_LSB];
      if (csr_wdata[TCFG_EN]) begin
        tval_d  = {csr_wdata[TIMER_N-1:TCFG_INITVAL_LSB], 2'b00};
        armed_d = 1'b1;
      end else begin
        tval_d  = tval_q;
        armed_d = 1'b0;
      end
    end else if (en_q && armed_q) begin
      if (tval_q != TVAL_ZERO) begin
        tval_d = tval_q - TVAL_ONE;
      end else begin
        expire = 1'b1;
        if (per_q) begin
          tval_d  = {initval_q, 2'b00};
          armed_d = 1'b1;
        end else begin
          tval_d  = TVAL_ONES;
          armed_d = 1'b0;
        end
      end
    end else begin
      tval_d = tval_q;
    end

    // expiry set beats a same-cycle TICLR clear
    if (expire) begin
      int_d = 1'b1;
    end else if (wr_ticlr && csr_wdata[TICLR_CLR]) begin
      int_d = 1'b0;
    end else begin
      int_d = int_q;
    end
  end

  // timer state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      tid_q     <= CPU_ID;
      en_q      <= 1'b0;
      per_q     <= 1'b0;
      initval_q <= {(TIMER_N-2){1'b0}};
      tval_q    <= TVAL_ONES;
      armed_q   <= 1'b0;
      int_q     <= 1'b0;
    end else begin
      tid_q     <= tid_d;
      en_q      <= en_d;
      per_q     <= per_d;
      initval_q <= initval_d;
      tval_q    <= tval_d;
      armed_q   <= armed_d;
      int_q     <= int_d;
    end
  end

  // read mux from current register values (no write bypass)
  always_comb begin
    rdata_mux = 32'h0000_0000;
    case (csr_num)
      CSR_TID:   rdata_mux = tid_q;
      CSR_TCFG:  rdata_mux = 32'({initval_q, per_q, en_q});
      CSR_TVAL:  rdata_mux = 32'(tval_q);
      CSR_TICLR: rdata_mux = 32'h0000_0000;
      default:   rdata_mux = 32'h0000_0000;
    endcase
  end

  assign csr_hit    = is_timer_csr(csr_num);
  assign csr_rdata  = (csr_re && csr_hit) ? rdata_mux : 32'h0000_0000;
  assign timer_int  = int_q;
  assign counter_id = tid_q;

  csr_timer_stable_counter u_stable_counter (
    .clk   (clk),
    .reset (reset),
    .cnt   (stable_cnt)
  );

endmodule

// File: tb/tb_csr_timer.sv
// Directed self-checking bench for csr_timer: reset, one-shot, periodic,
// clear/set collision, disable/re-enable, TVAL write-ignore and mid-count reset.
module tb_csr_timer;

  localparam logic [31:0] TB_CPU_ID = 32'h0000_0007;
  localparam logic [13:0] A_TID   = 14'h0040;
  localparam logic [13:0] A_TCFG  = 14'h0041;
  localparam logic [13:0] A_TVAL  = 14'h0042;
  localparam logic [13:0] A_TICLR = 14'h0044;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [13:0] csr_num = 14'h0000;
  logic        csr_re = 1'b0;
  logic        csr_we = 1'b0;
  logic [31:0] csr_wdata = 32'h0000_0000;
  logic        csr_hit;
  logic [31:0] csr_rdata;
  logic        timer_int;
  logic [63:0] stable_cnt;
  logic [31:0] counter_id;

  int          total = 0;
  int          bad = 0;
  logic [63:0] exp_sc = 64'd0;
  logic [31:0] rd;
  logic        hit;

  csr_timer #(.TIMER_N(32), .CPU_ID(TB_CPU_ID)) dut (
    .clk        (clk),
    .reset      (reset),
    .csr_num    (csr_num),
    .csr_re     (csr_re),
    .csr_we     (csr_we),
    .csr_wdata  (csr_wdata),
    .csr_hit    (csr_hit),
    .csr_rdata  (csr_rdata),
    .timer_int  (timer_int),
    .stable_cnt (stable_cnt),
    .counter_id (counter_id)
  );

  always #5 clk = ~clk;

  task automatic tick();
    logic rst_now;
    rst_now = reset;
    @(posedge clk);
    #1;
    exp_sc = rst_now ? 64'd0 : exp_sc + 64'd1;
  endtask

  task automatic csr_write(input logic [13:0] num, input logic [31:0] data);
    csr_we    = 1'b1;
    csr_num   = num;
    csr_wdata = data;
    tick();
    csr_we    = 1'b0;
    csr_wdata = 32'h0000_0000;
    csr_num   = 14'h0000;
  endtask

  task automatic csr_read(input logic [13:0] num, output logic [31:0] data, output logic h);
    csr_re  = 1'b1;
    csr_num = num;
    #1;
    data = csr_rdata;
    h    = csr_hit;
    csr_re  = 1'b0;
    csr_num = 14'h0000;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    total++; if (stable_cnt !== 64'd0) begin bad++; $display("FAIL rst_sc0 got=%0d exp=0", stable_cnt); end
    csr_read(A_TID, rd, hit);
    total++; if (rd !== TB_CPU_ID || hit !== 1'b1) begin bad++; $display("FAIL rst_tid got=%h/%b exp=%h/1", rd, hit, TB_CPU_ID); end
    csr_read(A_TCFG, rd, hit);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL rst_tcfg got=%h exp=0", rd); end
    csr_read(A_TVAL, rd, hit);
    total++; if (rd !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rst_tval got=%h exp=ffffffff", rd); end
    csr_read(A_TICLR, rd, hit);
    total++; if (rd !== 32'h0 || hit !== 1'b1) begin bad++; $display("FAIL rst_ticlr got=%h/%b exp=0/1", rd, hit); end
    csr_read(14'h0043, rd, hit);
    total++; if (rd !== 32'h0 || hit !== 1'b0) begin bad++; $display("FAIL miss_43 got=%h/%b exp=0/0", rd, hit); end
    csr_num = A_TID; #1;
    total++; if (csr_rdata !== 32'h0 || csr_hit !== 1'b1) begin bad++; $display("FAIL re_gate got=%h/%b exp=0/1", csr_rdata, csr_hit); end
    csr_num = 14'h0000;
    total++; if (timer_int !== 1'b0 || counter_id !== TB_CPU_ID) begin bad++; $display("FAIL rst_int_id got=%b/%h exp=0/%h", timer_int, counter_id, TB_CPU_ID); end
    for (int i = 1; i <= 2; i++) begin
      tick();
      total++; if (stable_cnt !== 64'(i)) begin bad++; $display("FAIL sc_inc got=%0d exp=%0d", stable_cnt, i); end
    end
  endtask

  task automatic test_tid();
    csr_write(A_TID, 32'hDEAD_BEEF);
    csr_read(A_TID, rd, hit);
    total++; if (rd !== 32'hDEAD_BEEF || counter_id !== 32'hDEAD_BEEF) begin bad++; $display("FAIL tid_wr got=%h/%h exp=deadbeef", rd, counter_id); end
  endtask

  task automatic test_oneshot();
    csr_write(A_TCFG, 32'h0000_0011);
    csr_read(A_TCFG, rd, hit);
    total++; if (rd !== 32'h0000_0011) begin bad++; $display("FAIL os_tcfg got=%h exp=11", rd); end
    csr_read(A_TVAL, rd, hit);
    total++; if (rd !== 32'd16) begin bad++; $display("FAIL os_load got=%0d exp=16", rd); end
    for (int k = 1; k <= 16; k++) begin
      tick();
      csr_read(A_TVAL, rd, hit);
      total++; if (rd !== 32'(16 - k) || timer_int !== 1'b0) begin bad++; $display("FAIL os_count k=%0d got=%0d/%b exp=%0d/0", k, rd, timer_int, 16 - k); end
    end
    tick();
    csr_read(A_TVAL, rd, hit);
    total++; if (timer_int !== 1'b1 || rd !== 32'hFFFF_FFFF) begin bad++; $display("FAIL os_expire got=%b/%h exp=1/ffffffff", timer_int, rd); end
    csr_write(A_TICLR, 32'h0000_0001);
    total++; if (timer_int !== 1'b0) begin bad++; $display("FAIL os_clr got=%b exp=0", timer_int); end
    for (int k = 0; k < 40; k++) tick();
    csr_read(A_TVAL, rd, hit);
    total++; if (timer_int !== 1'b0 || rd !== 32'hFFFF_FFFF) begin bad++; $display("FAIL os_norefire got=%b/%h exp=0/ffffffff", timer_int, rd); end
  endtask

  task automatic test_periodic();
    csr_write(A_TCFG, 32'h0000_000B);
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) tick();
      csr_read(A_TVAL, rd, hit);
      total++; if (rd !== 32'(8 - k) || timer_int !== 1'b0) begin bad++; $display("FAIL per_count k=%0d got=%0d/%b exp=%0d/0", k, rd, timer_int, 8 - k); end
    end
    tick();
    csr_read(A_TVAL, rd, hit);
    total++; if (timer_int !== 1'b1 || rd !== 32'd8) begin bad++; $display("FAIL per_exp1 got=%b/%0d exp=1/8", timer_int, rd); end
    csr_write(A_TICLR, 32'h0000_0001);
    csr_read(A_TVAL, rd, hit);
    total++; if (timer_int !== 1'b0 || rd !== 32'd7) begin bad++; $display("FAIL per_clr got=%b/%0d exp=0/7", timer_int, rd); end
    for (int k = 0; k < 7; k++) tick();
    total++; if (timer_int !== 1'b0) begin bad++; $display("FAIL per_early got=%b exp=0", timer_int); end
    tick();
    total++; if (timer_int !== 1'b1) begin bad++; $display("FAIL per_exp2 got=%b exp=1", timer_int); end
    total++; if (stable_cnt !== exp_sc) begin bad++; $display("FAIL sc_track got=%0d exp=%0d", stable_cnt, exp_sc); end
  endtask

  task automatic test_collision();
    csr_write(A_TICLR, 32'h0000_0001);
    total++; if (timer_int !== 1'b0) begin bad++; $display("FAIL col_pre got=%b exp=0", timer_int); end
    for (int k = 0; k < 7; k++) tick();
    csr_read(A_TVAL, rd, hit);
    total++; if (rd !== 32'd0) begin bad++; $display("FAIL col_tval0 got=%0d exp=0", rd); end
    csr_write(A_TICLR, 32'h0000_0001);
    csr_read(A_TVAL, rd, hit);
    total++; if (timer_int !== 1'b1 || rd !== 32'd8) begin bad++; $display("FAIL col_setwins got=%b/%0d exp=1/8", timer_int, rd); end
  endtask

  task automatic test_disable();
    csr_write(A_TCFG, 32'h0000_0011);
    for (int k = 0; k < 11; k++) tick();
    csr_read(A_TVAL, rd, hit);
    total++; if (rd !== 32'd5) begin bad++; $display("FAIL dis_at5 got=%0d exp=5", rd); end
    csr_write(A_TCFG, 32'h0000_0010);
    for (int k = 0; k < 6; k++) tick();
    csr_read(A_TVAL, rd, hit);
    total++; if (rd !== 32'd5 || timer_int !== 1'b1) begin bad++; $display("FAIL dis_frozen got=%0d/%b exp=5/1", rd, timer_int); end
    csr_read(A_TCFG, rd, hit);
    total++; if (rd !== 32'h0000_0010) begin bad++; $display("FAIL dis_tcfg got=%h exp=10", rd); end
    csr_write(A_TICLR, 32'h0000_0000);
    total++; if (timer_int !== 1'b1) begin bad++; $display("FAIL ticlr_bit0 got=%b exp=1", timer_int); end
    csr_write(A_TICLR, 32'h0000_0001);
    csr_write(A_TCFG, 32'h0000_0011);
    csr_read(A_TVAL, rd, hit);
    total++; if (rd !== 32'd16 || timer_int !== 1'b0) begin bad++; $display("FAIL reen_load got=%0d/%b exp=16/0", rd, timer_int); end
    csr_write(A_TVAL, 32'h0000_1234);
    csr_read(A_TVAL, rd, hit);
    total++; if (rd !== 32'd15) begin bad++; $display("FAIL tval_ro got=%0d exp=15", rd); end
  endtask

  task automatic test_reset_mid();
    csr_write(A_TCFG, 32'h0000_0003);
    tick();
    total++; if (timer_int !== 1'b1) begin bad++; $display("FAIL p0_set got=%b exp=1", timer_int); end
    for (int k = 0; k < 3; k++) begin
      csr_write(A_TICLR, 32'h0000_0001);
      total++; if (timer_int !== 1'b1) begin bad++; $display("FAIL p0_sticky k=%0d got=%b exp=1", k, timer_int); end
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (timer_int !== 1'b0 || stable_cnt !== 64'd0) begin bad++; $display("FAIL mrst_int_sc got=%b/%0d exp=0/0", timer_int, stable_cnt); end
    csr_read(A_TVAL, rd, hit);
    total++; if (rd !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mrst_tval got=%h exp=ffffffff", rd); end
    csr_read(A_TCFG, rd, hit);
    total++; if (rd !== 32'h0 || counter_id !== TB_CPU_ID) begin bad++; $display("FAIL mrst_tcfg_tid got=%h/%h exp=0/%h", rd, counter_id, TB_CPU_ID); end
    for (int k = 0; k < 10; k++) tick();
    total++; if (timer_int !== 1'b0 || stable_cnt !== 64'd10) begin bad++; $display("FAIL mrst_quiet got=%b/%0d exp=0/10", timer_int, stable_cnt); end
  endtask

  initial begin
    test_reset();
    test_tid();
    test_oneshot();
    test_periodic();
    test_collision();
    test_disable();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
